// File: rtl/display_request_arbiter_if.sv
// Request/acknowledge and converter handshake bundle for display_request_arbiter.
// The arbiter connects through the slave modport; requesters and converter drive the master side.
interface display_request_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic [DATA_WIDTH-1:0] data0;
    logic                  ack0;
    logic                  req1;
    logic [DATA_WIDTH-1:0] data1;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] bin_value;
    logic                  start_conversion;
    logic                  conversion_complete;
    logic                  active_source;
    logic                  busy;
    logic                  timeout_error;
    logic                  clear_error;

    modport master (
        output req0, data0, req1, data1, conversion_complete, clear_error,
        input  ack0, ack1, bin_value, start_conversion, active_source, busy, timeout_error
    );

    modport slave (
        input  req0, data0, req1, data1, conversion_complete, clear_error,
        output ack0, ack1, bin_value, start_conversion, active_source, busy, timeout_error
    );
endinterface

// File: rtl/display_request_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter and seven-segment display
// between two value sources, with a minimum display hold time and a conversion timeout.
module display_request_arbiter #(
    parameter int          DATA_WIDTH     = 8,
    parameter logic [31:0] HOLD_CYCLES    = 32'd100000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd64
) (
    input logic                   clk,
    input logic                   reset,
    display_request_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        CONVERT,
        HOLD
    } state_t;

    state_t                state, state_next;
    logic                  rr_last, rr_last_next;
    logic [31:0]           counter, counter_next;
    logic                  complete_q;
    logic                  done_evt;
    logic                  winner;

    logic                  ack0_r, ack0_next;
    logic                  ack1_r, ack1_next;
    logic [DATA_WIDTH-1:0] bin_r, bin_next;
    logic                  start_r, start_next;
    logic                  source_r, source_next;
    logic                  busy_r, busy_next;
    logic                  error_r, error_next;

    // Only a rising edge of the converter's done level counts, so a level left high
    // from an earlier conversion cannot complete the current one.
    assign done_evt = bus.conversion_complete & ~complete_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_last    <= 1'b1;
            counter    <= 32'd0;
            complete_q <= 1'b0;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            bin_r      <= '0;
            start_r    <= 1'b0;
            source_r   <= 1'b0;
            busy_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state      <= state_next;
            rr_last    <= rr_last_next;
            counter    <= counter_next;
            complete_q <= bus.conversion_complete;
            ack0_r     <= ack0_next;
            ack1_r     <= ack1_next;
            bin_r      <= bin_next;
            start_r    <= start_next;
            source_r   <= source_next;
            busy_r     <= busy_next;
            error_r    <= error_next;
        end
    end

    always_comb begin
        state_next   = state;
        rr_last_next = rr_last;
        counter_next = counter;
        ack0_next    = 1'b0;
        ack1_next    = 1'b0;
        start_next   = 1'b0;
        bin_next     = bin_r;
        source_next  = source_r;
        error_next   = error_r & ~bus.clear_error;
        winner       = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (bus.req0 | bus.req1) begin
                    winner       = (bus.req0 & bus.req1) ? ~rr_last : bus.req1;
                    rr_last_next = winner;
                    source_next  = winner;
                    bin_next     = winner ? bus.data1 : bus.data0;
                    ack0_next    = ~winner;
                    ack1_next    = winner;
                    start_next   = 1'b1;
                    state_next   = START;
                end
            end

            START: begin
                counter_next = 32'd0;
                state_next   = CONVERT;
            end

            CONVERT: begin
                if (done_evt) begin
                    counter_next = 32'd0;
                    state_next   = HOLD;
                end else if (counter == TIMEOUT_CYCLES - 32'd1) begin
                    counter_next = 32'd0;
                    error_next   = 1'b1;
                    state_next   = IDLE;
                end else begin
                    counter_next = counter + 32'd1;
                end
            end

            HOLD: begin
                if (counter == HOLD_CYCLES - 32'd1) begin
                    counter_next = 32'd0;
                    state_next   = IDLE;
                end else begin
                    counter_next = counter + 32'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.ack0             = ack0_r;
    assign bus.ack1             = ack1_r;
    assign bus.bin_value        = bin_r;
    assign bus.start_conversion = start_r;
    assign bus.active_source    = source_r;
    assign bus.busy             = busy_r;
    assign bus.timeout_error    = error_r;

endmodule

// File: tb/tb_display_request_arbiter.sv
// Cycle-by-cycle directed vectors for display_request_arbiter with HOLD_CYCLES=4 and
// TIMEOUT_CYCLES=8; each vector is driven before a rising edge and checked just after it.
module tb_display_request_arbiter;

    typedef struct {
        logic       rst;
        logic       r0;
        logic [7:0] d0;
        logic       r1;
        logic [7:0] d1;
        logic       cc;
        logic       clr;
        logic       a0;
        logic       a1;
        logic [7:0] bv;
        logic       sc;
        logic       src;
        logic       by;
        logic       te;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    display_request_arbiter_if #(.DATA_WIDTH(8)) bus ();

    display_request_arbiter #(
        .DATA_WIDTH    (8),
        .HOLD_CYCLES   (32'd4),
        .TIMEOUT_CYCLES(32'd8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic r0, input logic [7:0] d0,
        input logic r1, input logic [7:0] d1, input logic cc, input logic clr,
        input logic a0, input logic a1, input logic [7:0] bv,
        input logic sc, input logic src, input logic by, input logic te
    );
        vec_t v;
        v.rst = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.cc = cc; v.clr = clr;
        v.a0 = a0; v.a1 = a1; v.bv = bv; v.sc = sc; v.src = src; v.by = by; v.te = te;
        return v;
    endfunction

    task automatic check_output(input vec_t v, input string name);
        logic [13:0] got;
        logic [13:0] want;
        got  = {bus.ack0, bus.ack1, bus.bin_value, bus.start_conversion,
                bus.active_source, bus.busy, bus.timeout_error};
        want = {v.a0, v.a1, v.bv, v.sc, v.src, v.by, v.te};
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got ack0=%b ack1=%b bin=%h start=%b src=%b busy=%b err=%b, expected ack0=%b ack1=%b bin=%h start=%b src=%b busy=%b err=%b",
                     name, got[13], got[12], got[11:4], got[3], got[2], got[1], got[0],
                     want[13], want[12], want[11:4], want[3], want[2], want[1], want[0]);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input string name);
        @(negedge clk);
        reset                   = v.rst;
        bus.req0                = v.r0;
        bus.data0               = v.d0;
        bus.req1                = v.r1;
        bus.data1               = v.d1;
        bus.conversion_complete = v.cc;
        bus.clear_error         = v.clr;
        @(posedge clk);
        #1;
        check_output(v, name);
    endtask

    // One full tie transaction with both requests held high throughout.
    task automatic tie_round(input logic w, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] bv;
        bv = w ? d1 : d0;
        apply_stimulus(mk(0, 1, d0, 1, d1, 0, 0, ~w, w, bv, 1, w, 1, 0), "tie_grant");
        apply_stimulus(mk(0, 1, d0, 1, d1, 0, 0, 0, 0, bv, 0, w, 1, 0), "tie_start");
        apply_stimulus(mk(0, 1, d0, 1, d1, 0, 0, 0, 0, bv, 0, w, 1, 0), "tie_convert");
        apply_stimulus(mk(0, 1, d0, 1, d1, 1, 0, 0, 0, bv, 0, w, 1, 0), "tie_done");
        for (int i = 0; i < 4; i++)
            apply_stimulus(mk(0, 1, d0, 1, d1, 1, 0, 0, 0, bv, 0, w, logic'(i < 3), 0),
                           $sformatf("tie_hold%0d", i));
    endtask

    // Sole requester w, converter done level fixed at cc, no completion ever seen.
    task automatic timeout_run(input logic w, input logic [7:0] d, input logic cc,
                               input logic te_before, input logic clr_last,
                               input logic te_after);
        apply_stimulus(mk(0, ~w, d, w, d, cc, 0, ~w, w, d, 1, w, 1, te_before), "to_grant");
        apply_stimulus(mk(0, 0, d, 0, d, cc, 0, 0, 0, d, 0, w, 1, te_before), "to_start");
        for (int i = 0; i < 8; i++)
            apply_stimulus(mk(0, 0, d, 0, d, cc, (i == 7) ? clr_last : 1'b0,
                              0, 0, d, 0, w, logic'(i < 7), (i < 7) ? te_before : te_after),
                           $sformatf("to_convert%0d", i));
    endtask

    vec_t table_v[21];

    initial begin
        clk                     = 1'b0;
        reset                   = 1'b1;
        bus.req0                = 1'b0;
        bus.data0               = 8'd0;
        bus.req1                = 1'b0;
        bus.data1               = 8'd0;
        bus.conversion_complete = 1'b0;
        bus.clear_error         = 1'b0;
        checks                  = 0;
        failures                = 0;

        table_v[0]  = mk(1, 0, 8'd0,   0, 8'h00, 0, 0, 0, 0, 8'd0,   0, 0, 0, 0);
        table_v[1]  = mk(0, 0, 8'd0,   0, 8'h00, 0, 0, 0, 0, 8'd0,   0, 0, 0, 0);
        table_v[2]  = mk(0, 1, 8'd173, 0, 8'h00, 0, 0, 1, 0, 8'd173, 1, 0, 1, 0);
        table_v[3]  = mk(0, 0, 8'd173, 0, 8'h00, 0, 0, 0, 0, 8'd173, 0, 0, 1, 0);
        table_v[4]  = mk(0, 0, 8'd173, 0, 8'h00, 0, 0, 0, 0, 8'd173, 0, 0, 1, 0);
        table_v[5]  = mk(0, 0, 8'd173, 0, 8'h00, 1, 0, 0, 0, 8'd173, 0, 0, 1, 0);
        table_v[6]  = mk(0, 0, 8'd173, 0, 8'h00, 1, 0, 0, 0, 8'd173, 0, 0, 1, 0);
        table_v[7]  = mk(0, 0, 8'd173, 1, 8'h5A, 1, 0, 0, 0, 8'd173, 0, 0, 1, 0);
        table_v[8]  = mk(0, 0, 8'd173, 1, 8'h5A, 1, 0, 0, 0, 8'd173, 0, 0, 1, 0);
        table_v[9]  = mk(0, 0, 8'd173, 1, 8'h5A, 1, 0, 0, 0, 8'd173, 0, 0, 0, 0);
        table_v[10] = mk(0, 0, 8'd173, 1, 8'h5A, 0, 0, 0, 1, 8'h5A,  1, 1, 1, 0);
        table_v[11] = mk(0, 0, 8'd173, 0, 8'h5A, 0, 0, 0, 0, 8'h5A,  0, 1, 1, 0);
        table_v[12] = mk(0, 0, 8'd173, 0, 8'h5A, 0, 0, 0, 0, 8'h5A,  0, 1, 1, 0);
        table_v[13] = mk(0, 0, 8'd173, 0, 8'h5A, 1, 0, 0, 0, 8'h5A,  0, 1, 1, 0);
        table_v[14] = mk(0, 0, 8'd173, 0, 8'h5A, 1, 0, 0, 0, 8'h5A,  0, 1, 1, 0);
        table_v[15] = mk(0, 0, 8'd173, 0, 8'h5A, 1, 0, 0, 0, 8'h5A,  0, 1, 1, 0);
        table_v[16] = mk(0, 1, 8'hEE,  0, 8'h5A, 1, 0, 0, 0, 8'h5A,  0, 1, 1, 0);
        table_v[17] = mk(0, 1, 8'hEE,  0, 8'h5A, 1, 0, 0, 0, 8'h5A,  0, 1, 0, 0);
        table_v[18] = mk(0, 0, 8'hEE,  0, 8'h5A, 0, 0, 0, 0, 8'h5A,  0, 1, 0, 0);
        table_v[19] = mk(1, 1, 8'h11,  1, 8'h22, 0, 0, 0, 0, 8'd0,   0, 0, 0, 0);
        table_v[20] = mk(0, 1, 8'h11,  1, 8'h22, 0, 0, 1, 0, 8'h11,  1, 0, 1, 0);

        for (int i = 0; i < 21; i++)
            apply_stimulus(table_v[i], $sformatf("table[%0d]", i));

        apply_stimulus(mk(1, 1, 8'h30, 1, 8'h40, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0), "tie_reset");
        for (int k = 0; k < 4; k++)
            tie_round(logic'(k[0]), 8'(8'h30 + k), 8'(8'h40 + k));

        timeout_run(1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(mk(0, 0, 8'h99, 0, 8'h99, 0, 1, 0, 0, 8'h99, 0, 0, 0, 0), "clear_error");
        timeout_run(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
        apply_stimulus(mk(0, 0, 8'h77, 0, 8'h77, 0, 1, 0, 0, 8'h77, 0, 1, 0, 0), "clear_again");

        timeout_run(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);

        apply_stimulus(mk(0, 1, 8'h55, 0, 8'h00, 0, 0, 1, 0, 8'h55, 1, 0, 1, 1), "mid_grant");
        apply_stimulus(mk(0, 0, 8'h55, 0, 8'h00, 0, 0, 0, 0, 8'h55, 0, 0, 1, 1), "mid_start");
        apply_stimulus(mk(0, 0, 8'h55, 0, 8'h00, 0, 0, 0, 0, 8'h55, 0, 0, 1, 1), "mid_convert");
        apply_stimulus(mk(1, 1, 8'hA1, 1, 8'hB2, 0, 0, 0, 0, 8'd0,  0, 0, 0, 0), "mid_reset");
        apply_stimulus(mk(0, 1, 8'hA1, 1, 8'hB2, 0, 0, 1, 0, 8'hA1, 1, 0, 1, 0), "post_reset_tie");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_request_arbiter.md
Name: display_request_arbiter

Overview:
- Shares the single integer seven-segment display path (binary-to-BCD converter plus display controller) between two value sources, e.g. the classifier result and a debug/status value.
- Arbitrates requests round-robin, loads the winning 8-bit value and fires a one-cycle start pulse into the converter.
- Waits for conversion complete, then holds the display for a minimum time before serving the next request.
- Sits between the requesters and the integer seven-segment display controller.

Parameters:
- DATA_WIDTH, 8, width of each requester value and of bin_value.
- HOLD_CYCLES, 32'd100000, clk cycles a converted value stays displayed before the next grant. Must be ≥1.
- TIMEOUT_CYCLES, 32'd64, max clk cycles spent waiting for conversion complete. Must be ≥2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants data0 displayed. Held until ack0.
- data0  input  DATA_WIDTH  requester 0 value. Must be stable while req0 is high.
- req1  input  1  requester 1 request.
- data1  input  DATA_WIDTH  requester 1 value.
- ack0  output  1  one-cycle acknowledge: data0 captured.
- ack1  output  1  one-cycle acknowledge: data1 captured.
- bin_value  output  DATA_WIDTH  value driven to converter binary_data.
- start_conversion  output  1  one-cycle converter start pulse.
- conversion_complete  input  1  converter done level.
- active_source  output  1  source of bin_value: 0 for requester 0, 1 for requester 1.
- busy  output  1  high in any state other than IDLE.
- timeout_error  output  1  sticky flag: a conversion timed out.
- clear_error  input  1  clears timeout_error.

Behaviour:
- All outputs are registered. Clock and reset names are fixed: clk, reset (synchronous, active-high).
- Reset values: ack0=ack1=0, bin_value=0, start_conversion=0, active_source=0, busy=0, timeout_error=0. State=IDLE, rr_last=1 (requester 0 wins the first tie), counter=0, complete_q=0.
- States and transitions:
  - IDLE: if any req at edge N, winner = sole requester; if both request, winner = the one not equal to rr_last. At edge N the block captures bin_value<=data_w, active_source<=w, rr_last<=w, and sets ack_w=1 and start_conversion=1, both visible in cycle N+1 only. Next state START. No req: stay in IDLE.
  - START: single cycle, pulse deasserts. Counter<=0. Next state CONVERT.
  - CONVERT: done_evt = conversion_complete & ~complete_q, where complete_q is conversion_complete registered every cycle. done_evt -> HOLD, counter<=0. Otherwise counter increments; when counter==TIMEOUT_CYCLES-1 without done_evt, timeout_error<=1, next state IDLE (no hold). Value remains on bin_value.
  - HOLD: counter increments; at counter==HOLD_CYCLES-1 -> IDLE. Requests are ignored in HOLD (not acked).
- Latency: req to ack/start is 1 cycle. Minimum req-to-req turnaround = 1 (IDLE) + 1 (START) + conversion time + HOLD_CYCLES.
- Request handling:
  - A req dropped before ack is withdrawn silently.
  - A req still high the cycle after its ack is treated as a new request at the next IDLE.
  - A losing requester keeps req high and is served next, per round-robin.
- done_evt in IDLE, START or HOLD is ignored; only CONVERT consumes it.
- Simultaneous clear_error and timeout in the same edge: set wins (timeout_error=1).
- Reset mid-operation: returns everything to reset values the next edge. No ack or start is issued in the reset cycle.
- Counter is 32 bits with no wrap in the reachable range.

Test Plan (HOLD_CYCLES=4, TIMEOUT_CYCLES=8, converter model asserts complete 3 cycles after start):
- Single request: req0=1, data0=8'd173 at edge N (IDLE) -> cycle N+1: ack0=1, start_conversion=1, bin_value=173, active_source=0, busy=1. Both pulses low at N+2. busy low 4 cycles after done_evt.
- Tie after reset: req0=req1=1 together -> ack0 first (data0 shown). req1 held -> ack1 at the next IDLE. Repeated ties alternate 0,1,0,1.
- Request during HOLD: req1 rises during HOLD -> no ack1 until state returns to IDLE. Then ack1 appears 1 cycle later with bin_value=data1.
- Timeout: converter never completes -> timeout_error=1 exactly 8 cycles after entering CONVERT, state IDLE, busy=0. clear_error=1 for one cycle -> timeout_error=0. clear_error coincident with a second timeout -> stays 1.
- Stale complete: conversion_complete stuck high from before the start -> no done_evt. Block times out (timeout_error=1) rather than entering HOLD.
- Reset mid-CONVERT: reset=1 for one cycle -> next cycle all outputs at reset values, state IDLE. Tie then grants requester 0.
